// File: rtl/dac_spi_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_tx_pkg
//  Description : Shared types and constants for the serial DAC output stage.
//                FSM state encoding, overrun counter width and a saturating
//                increment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package dac_spi_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam int C_OVR_CNT_W = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [C_OVR_CNT_W-1:0] sat_inc(input logic [C_OVR_CNT_W-1:0] v);
        return (v == '1) ? v : v + C_OVR_CNT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac_spi_tx_clk_div_tick.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_tick
//  Description : Free-running divider producing a one-cycle tick every DIV
//                enabled clocks.
//  Ports       : clk   - system clock
//                reset - asynchronous active-high reset
//                en    - counter runs while high
//                clr   - synchronous clear to zero (wins over en)
//                tick  - high on the cycle the counter wraps
//  Revision    : 1.0  initial release
// ============================================================================
module clk_div_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int                 c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + c_CNT_W'(1);
        end
    end

    assign tick = en & ~clr & (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/dac_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_tx
//  Description : Serialises each filtered sample to an external SPI DAC
//                (mode 0, MSB first, one frame per sample) through a one-deep
//                holding buffer. Overwrites of an unsent buffered sample are
//                flagged and counted.
//  Ports       : clk          - system clock
//                reset        - asynchronous active-high reset
//                data_in      - filtered sample, DATA_SIZE-1 bits
//                data_valid   - rising edge marks a new sample
//                dac_sclk     - SPI clock, idle low
//                dac_cs_n     - SPI chip select, active low
//                dac_mosi     - serial data, MSB first
//                busy         - frame in progress (any state but idle)
//                tx_done      - one-cycle pulse as chip select releases
//                overrun      - one-cycle pulse on buffered-sample overwrite
//                overrun_cnt  - saturating overrun count
//  Revision    : 1.0  initial release
// ============================================================================
module dac_spi_tx
    import dac_spi_tx_pkg::*;
#(
    parameter int DATA_SIZE  = 25,
    parameter int CLK_DIV    = 4,
    parameter bit OFFSET_BIN = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_SIZE-2:0]   data_in,
    input  logic                   data_valid,
    output logic                   dac_sclk,
    output logic                   dac_cs_n,
    output logic                   dac_mosi,
    output logic                   busy,
    output logic                   tx_done,
    output logic                   overrun,
    output logic [C_OVR_CNT_W-1:0] overrun_cnt
);

    localparam int                 c_N        = DATA_SIZE - 1;
    localparam int                 c_TOG_W    = $clog2(2 * c_N);
    localparam logic [c_TOG_W-1:0] c_TOG_LAST = c_TOG_W'(2 * c_N - 1);

    state_t                   r_state;
    logic                     r_dv_prev;
    logic [c_N-1:0]           r_buf;
    logic                     r_buf_valid;
    // Holds only the bits still to send after the MSB, which goes straight
    // to mosi when the frame is loaded.
    logic [c_N-2:0]           r_shift;
    logic [c_TOG_W-1:0]       r_tog;
    logic                     r_sclk;
    logic                     r_cs_n;
    logic                     r_mosi;
    logic                     r_busy;
    logic                     r_tx_done;
    logic                     r_overrun;
    logic [C_OVR_CNT_W-1:0]   r_ovr_cnt;

    logic [c_N-1:0]           w_sample;
    logic                     w_edge;
    logic                     w_take;
    logic                     w_tick;

    if (OFFSET_BIN) begin : g_offset_bin
        assign w_sample = {~data_in[c_N-1], data_in[c_N-2:0]};
    end else begin : g_twos_comp
        assign w_sample = data_in;
    end

    assign w_edge = data_valid & ~r_dv_prev;
    // The FSM consumes the buffer on the idle cycle it sees it full.
    assign w_take = (r_state == ST_IDLE) & r_buf_valid;

    clk_div_tick #(
        .DIV (CLK_DIV)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .en    (r_state != ST_IDLE),
        .clr   (w_take),
        .tick  (w_tick)
    );

    // Edge detect, holding buffer and overrun accounting. A new edge in the
    // same cycle the FSM takes the buffer refills it rather than overwriting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dv_prev   <= 1'b0;
            r_buf       <= '0;
            r_buf_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_ovr_cnt   <= '0;
        end else begin
            r_dv_prev <= data_valid;
            r_overrun <= 1'b0;
            if (w_edge) begin
                r_buf       <= w_sample;
                r_buf_valid <= 1'b1;
                if (r_buf_valid && !w_take) begin
                    r_overrun <= 1'b1;
                    r_ovr_cnt <= sat_inc(r_ovr_cnt);
                end
            end else if (w_take) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

    // Frame sequencer: setup tick, 2N sclk toggles, hold tick, gap tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_tog     <= '0;
            r_sclk    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_tx_done <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_buf_valid) begin
                        r_shift <= r_buf[c_N-2:0];
                        r_mosi  <= r_buf[c_N-1];
                        r_cs_n  <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_tog   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_tick) begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        r_sclk <= ~r_sclk;
                        r_tog  <= r_tog + c_TOG_W'(1);
                        // Falling sclk edge: present the next bit.
                        if (r_sclk) begin
                            r_mosi  <= r_shift[c_N-2];
                            r_shift <= {r_shift[c_N-3:0], 1'b0};
                        end
                        if (r_tog == c_TOG_LAST) begin
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        r_cs_n    <= 1'b1;
                        r_mosi    <= 1'b0;
                        r_tx_done <= 1'b1;
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dac_sclk    = r_sclk;
    assign dac_cs_n    = r_cs_n;
    assign dac_mosi    = r_mosi;
    assign busy        = r_busy;
    assign tx_done     = r_tx_done;
    assign overrun     = r_overrun;
    assign overrun_cnt = r_ovr_cnt;

endmodule
`default_nettype wire
